booth_pp_gen: RTL
=================

Name: booth_pp_gen

Overview:
- Iterative radix-4 Booth partial-product generator. It is the producer side of the Wallace-tree input interface.
- It accepts a signed 32x32 multiply via valid/ready and encodes LANES Booth digits per cycle into a registered 1024-bit partial-product bus plus the `spe_component` negation-correction word.
- It then presents the complete set to the tree through a valid/ready output stage.
- The tree applies the per-row `<< 2i` weighting itself, so rows are emitted unshifted.

Parameters:
- LANES, 4, Booth digits encoded per cycle. Legal values: 1, 2, 4, 8, 16. Other values are a compile-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  32  multiplicand, two's complement.
- in_b  input  32  multiplier, two's complement.
- out_valid  output  1  `prod0` / `spe_component` hold a complete, stable set.
- out_ready  input  1  tree side accepts the set.
- prod0  output  1024  row i occupies bits [64i+63:64i], for i = 0..15, unshifted.
- spe_component  output  64  negation-correction bits.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - state=IDLE.
  - in_ready=1, out_valid=0.
  - prod0=0, spe_component=0.
  - Digit counter = 0.
  - Operand registers = 0.
- States: IDLE, ENC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a into A and {in_b, 1'b0} into Bx, clear prod0 and spe_component, set counter=0, go to ENC.
- ENC:
  - in_ready=0.
  - Each cycle, encode digits k = counter .. counter+LANES-1.
  - Triplet for digit k is (b[2k+1], b[2k], b[2k-1]), with b[-1]=0.
  - Triplet-to-digit map: 000/111 → 0; 001/010 → +1; 011 → +2; 100 → -2; 101/110 → -1.
  - Magnitude M = A sign-extended to 64 bits, times |d| (×2 is a 1-bit left shift).
  - Row k: d=0 → 64'h0. d>0 → M. d<0 → ~M.
  - spe_component[2k] = (d<0). All odd bits of spe_component, and bits ≥32, stay 0.
  - counter += LANES. When counter+LANES = 16, go to DONE.
- DONE:
  - out_valid=1; outputs held stable.
  - On out_ready: go to IDLE and drop out_valid in that same edge.
  - New operands are not accepted until the following cycle (in_ready=1 only in IDLE).
- Latency:
  - Accept edge → out_valid high after 16/LANES ENC cycles.
  - LANES=4: in_valid sampled at edge 0, out_valid visible after edge 4.
  - Throughput is one operation per 16/LANES+2 cycles.
- Arithmetic invariant: Σ_i (prod0 row i << 2i) + spe_component ≡ A·B (mod 2^64), with A and B signed.
- in_valid during ENC or DONE is ignored, not captured; the upstream must hold it.
- A 0 digit never sets its negation bit, including the 111 triplet.
- Most negative operands (0x80000000 for either input) must produce exact products. No special casing.
- Reset asserted mid-ENC or in DONE aborts immediately to reset values. No partial set is ever shown with out_valid=1.
- Rows not yet encoded read 0 during ENC. out_valid stays low, so the tree must not sample them.

Test Plan:
- A=3, B=5, LANES=4:
  - row0=3, row1=3, other rows 0, spe=0.
  - Reduced sum=15.
  - out_valid after exactly 4 ENC cycles.
- A=0xFFFFFFFF, B=0xFFFFFFFF:
  - Digit0=-1, so row0=64'h0 and spe=64'h1.
  - All other rows 0; reduced sum=1.
- A=0x7FFFFFFF, B=0x80000000:
  - Only digit15=-2; row15=~(2·sext(A)).
  - spe bit30=1; reduced sum=0xC000000080000000.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → outputs and out_valid stable, in_ready=0, new in_valid ignored.
  - Then out_ready=1 → IDLE next cycle.
- Reset mid-ENC (after 2 cycles) → all outputs 0 immediately, in_ready=1.
  - A following A=-7, B=9 completes with reduced sum 0xFFFFFFFFFFFFFFC1.
- Randomised 10k operand pairs at LANES=1, 4, 16:
  - Reduced sum equals the 64-bit signed product.
  - Latency equals 16/LANES.

Source files
------------

// File: rtl/booth_pp_gen.sv
// Iterative radix-4 Booth partial-product generator feeding a Wallace tree.
// Encodes LANES Booth digits per cycle into 16 unshifted 64-bit rows plus the
// negation-correction word, then holds the complete set behind valid/ready.
module booth_pp_gen #(
    parameter int unsigned LANES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] prod0,
    output logic [63:0]   spe_component
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("booth_pp_gen: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] a_reg;
    logic [32:0] bx_reg;   // {multiplier, 1'b0}: bit 0 is the implicit b[-1]
    logic [4:0]  counter;
    logic [63:0] a_ext;

    logic [3:0]  digit_idx [LANES];
    logic [63:0] lane_row  [LANES];
    logic        lane_neg  [LANES];

    assign a_ext = {{32{a_reg[31]}}, a_reg};

    // Map one Booth triplet to {negate, row}; negative digits give ~M and the
    // +1 completing the two's complement is carried in the negation bit.
    function automatic logic [64:0] booth_encode(input logic [2:0] trip, input logic [63:0] m1);
        logic [63:0] m2;
        m2 = m1 << 1;
        case (trip)
            3'b001, 3'b010: return {1'b0, m1};
            3'b011:         return {1'b0, m2};
            3'b100:         return {1'b1, ~m2};
            3'b101, 3'b110: return {1'b1, ~m1};
            default:        return '0;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = ENC;
                end
            end
            ENC: begin
                if (counter == 5'(16 - LANES)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Booth-encode the LANES digits selected by the current counter value.
    always_comb begin
        for (int unsigned j = 0; j < LANES; j++) begin
            digit_idx[j] = counter[3:0] + 4'(j);
            {lane_neg[j], lane_row[j]} =
                booth_encode(bx_reg[{1'b0, digit_idx[j], 1'b0} +: 3], a_ext);
        end
    end

    // Operand capture and row/negation-bit accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            bx_reg        <= '0;
            counter       <= '0;
            prod0         <= '0;
            spe_component <= '0;
        end else if (state == IDLE && in_valid) begin
            a_reg         <= in_a;
            bx_reg        <= {in_b, 1'b0};
            counter       <= '0;
            prod0         <= '0;
            spe_component <= '0;
        end else if (state == ENC) begin
            for (int unsigned j = 0; j < LANES; j++) begin
                prod0[{digit_idx[j], 6'b0} +: 64]             <= lane_row[j];
                spe_component[{1'b0, digit_idx[j], 1'b0}]     <= lane_neg[j];
            end
            counter <= counter + 5'(LANES);
        end
    end

endmodule
